// File: rtl/mul_reg_seq_ctrl.sv
// Sequencer that runs the per-PE multiplier register file as an in-order (N-1)-deep
// delay line: accepts a programmed number of products per pass, then drains the residue.
//
// state | meaning
// IDLE  | waiting for start_i; len_i latched on start
// RUN   | accepting products; write and read share the rotating pointer
// DRAIN | replaying the remaining stored products in accept order
// DONE  | one-cycle done pulse; pass bookkeeping cleared
module mul_reg_seq_ctrl #(
    parameter int N           = 3,
    parameter int ADDRS_WIDTH = $clog2(N-1),
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk_i,
    input  logic                   mreg_rst_i,
    input  logic                   start_i,
    input  logic [CNT_WIDTH-1:0]   len_i,
    input  logic                   data_valid_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   mreg_wr_en_o,
    output logic [ADDRS_WIDTH-1:0] mreg_wr_addrs_o,
    output logic [ADDRS_WIDTH-1:0] mreg_rd_addrs_o,
    output logic                   rd_valid_o
);

    localparam int FILL_WIDTH = $clog2(N);
    localparam logic [ADDRS_WIDTH-1:0] LAST_ADDRS = ADDRS_WIDTH'(N-2);
    localparam logic [FILL_WIDTH-1:0]  FULL       = FILL_WIDTH'(N-1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [ADDRS_WIDTH-1:0] ptr_q, ptr_nxt, dptr_q, dptr_nxt;
    logic [FILL_WIDTH-1:0]  fill_q, fill_nxt, drain_cnt_q;
    logic [CNT_WIDTH-1:0]   len_q, acc_cnt_q;
    logic                   accept, last_accept;

    // N-1 need not be a power of two, so wrap by compare rather than overflow
    assign ptr_nxt     = (ptr_q == LAST_ADDRS) ? '0 : ptr_q + ADDRS_WIDTH'(1);
    assign dptr_nxt    = (dptr_q == LAST_ADDRS) ? '0 : dptr_q + ADDRS_WIDTH'(1);
    assign fill_nxt    = (fill_q == FULL) ? FULL : fill_q + FILL_WIDTH'(1);
    assign accept      = (state_q == RUN) && data_valid_i;
    assign last_accept = accept && ((acc_cnt_q + CNT_WIDTH'(1)) == len_q);

    always_ff @(posedge clk_i or posedge mreg_rst_i) begin
        if (mreg_rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or posedge mreg_rst_i) begin
        if (mreg_rst_i) begin
            ptr_q       <= '0;
            dptr_q      <= '0;
            fill_q      <= '0;
            drain_cnt_q <= '0;
            len_q       <= '0;
            acc_cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        len_q     <= len_i;
                        ptr_q     <= '0;
                        fill_q    <= '0;
                        acc_cnt_q <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        ptr_q     <= ptr_nxt;
                        fill_q    <= fill_nxt;
                        acc_cnt_q <= acc_cnt_q + CNT_WIDTH'(1);
                        // oldest surviving entry sits at the next write slot once the store is full
                        if (last_accept) begin
                            dptr_q      <= (fill_nxt == FULL) ? ptr_nxt : '0;
                            drain_cnt_q <= fill_nxt;
                        end
                    end
                end
                DRAIN: begin
                    dptr_q      <= dptr_nxt;
                    drain_cnt_q <= drain_cnt_q - FILL_WIDTH'(1);
                end
                DONE: begin
                    ptr_q     <= '0;
                    fill_q    <= '0;
                    acc_cnt_q <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d         = state_q;
        busy_o          = 1'b0;
        done_o          = 1'b0;
        mreg_wr_en_o    = 1'b0;
        mreg_wr_addrs_o = '0;
        mreg_rd_addrs_o = '0;
        rd_valid_o      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = (len_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy_o = 1'b1;
                if (accept) begin
                    mreg_wr_en_o    = 1'b1;
                    mreg_wr_addrs_o = ptr_q;
                    mreg_rd_addrs_o = ptr_q;
                    rd_valid_o      = (fill_q == FULL);
                end
                if (last_accept) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                busy_o          = 1'b1;
                mreg_rd_addrs_o = dptr_q;
                rd_valid_o      = 1'b1;
                if (drain_cnt_q == FILL_WIDTH'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
